// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu
// Purpose  : Multi-cycle ALU with valid/ready handshakes. Mul/div share one
//            iterative bit-serial engine; other ops complete in one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module seq_alu #(
    parameter int XLEN = 64,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [XLEN-1:0] X,
    input  logic [XLEN-1:0] Y,
    input  logic [3:0]      OP,
    input  logic            ABORT,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [XLEN-1:0] RESULT,
    output logic            IS_EQUAL
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [SHW:0] CNT_INIT = (SHW+1)'(XLEN);
    localparam logic [SHW:0] CNT_LAST = (SHW+1)'(1);

    state_t            state, state_nxt;
    logic [3:0]        op_q;
    logic              neg_q;
    logic [XLEN-1:0]   b_q;
    logic [2*XLEN-1:0] acc_q;
    logic [SHW:0]      cnt_q;

    logic              accept, is_mul, is_div, last;
    logic [SHW-1:0]    shamt;
    logic [XLEN-1:0]   alu, x_mag, y_mag, eng_res;
    logic [XLEN:0]     mul_sum, div_trial;
    logic [2*XLEN-1:0] mul_nxt, mul_neg, div_nxt;

    assign IS_EQUAL  = (X == Y);
    assign IN_READY  = (state == IDLE);
    assign OUT_VALID = (state == DONE);

    assign accept = IN_VALID && (state == IDLE) && !ABORT;
    assign is_mul = (OP == 4'd8) || (OP == 4'd9) || (OP == 4'd14);
    assign is_div = ((OP == 4'd10) || (OP == 4'd11)) && (Y != '0);
    assign last   = (cnt_q == CNT_LAST);
    assign shamt  = Y[SHW-1:0];

    // Signed high-multiply runs on magnitudes; sign is reapplied at the end
    assign x_mag = ((OP == 4'd9) && X[XLEN-1]) ? -X : X;
    assign y_mag = ((OP == 4'd9) && Y[XLEN-1]) ? -Y : Y;

    always_comb begin
        alu = X + Y;
        case (OP)
            4'd1:    alu = X - Y;
            4'd2:    alu = X & Y;
            4'd3:    alu = X | Y;
            4'd4:    alu = X ^ Y;
            4'd5:    alu = X << shamt;
            4'd6:    alu = X >> shamt;
            4'd7:    alu = $signed(X) >>> shamt;
            4'd10:   alu = '1;
            4'd11:   alu = X;
            4'd12:   alu = {{(XLEN-1){1'b0}}, ($signed(X) < $signed(Y))};
            4'd13:   alu = {{(XLEN-1){1'b0}}, (X < Y)};
            default: alu = X + Y;
        endcase
    end

    // Shift-add: add multiplicand into the upper half, shift the pair right
    assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_q};
    assign mul_nxt = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]}
                              : {1'b0, acc_q[2*XLEN-1:1]};
    assign mul_neg = -mul_nxt;

    // Restoring divide: upper half is the remainder, lower half shifts in quotient
    assign div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
    assign div_nxt   = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                       : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    always_comb begin
        eng_res = mul_nxt[XLEN-1:0];
        case (op_q)
            4'd9:    eng_res = neg_q ? mul_neg[2*XLEN-1:XLEN] : mul_nxt[2*XLEN-1:XLEN];
            4'd14:   eng_res = mul_nxt[2*XLEN-1:XLEN];
            4'd10:   eng_res = div_nxt[XLEN-1:0];
            4'd11:   eng_res = div_nxt[2*XLEN-1:XLEN];
            default: eng_res = mul_nxt[XLEN-1:0];
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_mul)      state_nxt = MUL;
                    else if (is_div) state_nxt = DIV;
                    else             state_nxt = DONE;
                end
            end
            MUL, DIV: begin
                if (ABORT)     state_nxt = IDLE;
                else if (last) state_nxt = DONE;
            end
            DONE: begin
                if (ABORT || OUT_READY) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            op_q   <= '0;
            neg_q  <= 1'b0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            RESULT <= '0;
        end else if (accept) begin
            op_q  <= OP;
            neg_q <= (OP == 4'd9) && (X[XLEN-1] ^ Y[XLEN-1]);
            b_q   <= is_div ? Y : y_mag;
            acc_q <= {{XLEN{1'b0}}, (is_div ? X : x_mag)};
            cnt_q <= CNT_INIT;
            if (!is_mul && !is_div) RESULT <= alu;
        end else if (state == MUL || state == DIV) begin
            acc_q <= (state == MUL) ? mul_nxt : div_nxt;
            cnt_q <= cnt_q - CNT_LAST;
            if (last && !ABORT) RESULT <= eng_res;
        end
    end

endmodule
`default_nettype wire

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the single-cycle ALU used by the execute stage.
- Width is set by XLEN. Input and output each use a valid/ready handshake.
- Multiply and divide run on a shared iterative engine of one bit per cycle; all other ops complete in one registered cycle.
- Adds: signed and unsigned high-multiply, a defined divide-by-zero result, shift-amount masking, and an abort input so the pipeline can squash an operation in flight.

Parameters:
- XLEN, 64: operand and result width; must be a power of two, at least 8.
- SHW, log2(XLEN): shift-amount width (derived; do not override).

Ports:
- CLK  input  1  rising-edge clock.
- RESET_N  input  1  asynchronous, active-low reset.
- IN_VALID  input  1  operands and OP are valid.
- IN_READY  output  1  block accepts a new operation.
- X  input  XLEN  operand A.
- Y  input  XLEN  operand B.
- OP  input  4  operation code.
- ABORT  input  1  squash any op in flight.
- OUT_VALID  output  1  RESULT is valid.
- OUT_READY  input  1  consumer takes RESULT.
- RESULT  output  XLEN  registered result.
- IS_EQUAL  output  1  combinational X==Y for branch compare; independent of the FSM.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (RESET_N).
  - State goes to IDLE.
  - RESULT=0, OUT_VALID=0.
  - All engine registers are cleared.
  - IN_READY=1 once reset is released.
- Accept: an op is accepted on a rising edge where IN_VALID=1 and IN_READY=1. IN_READY=1 only in IDLE.
- OP encoding:
  - 0 add; 1 sub; 2 and; 3 or; 4 xor.
  - 5 sll; 6 srl; 7 sra. Shift amount is Y[SHW-1:0]; upper Y bits are ignored.
  - 8 mul, low XLEN bits.
  - 9 mulh, signed×signed, high XLEN bits.
  - 10 divu; 11 remu.
  - 12 slt, signed; 13 sltu.
  - 14 mulhu, unsigned×unsigned, high XLEN bits.
  - 15 is treated as add.
- Arithmetic wraps modulo 2^XLEN. slt and sltu return 0 or 1, zero-extended.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE → DONE: single-cycle ops (0–7, 12–15 other than 14, 15) and divide with Y==0. Result is registered on the accept edge, so OUT_VALID is high the next cycle (latency 1).
  - IDLE → MUL: ops 8, 9, 14.
  - IDLE → DIV: ops 10 and 11 with Y≠0.
- MUL:
  - Shift-add engine over a 2·XLEN product, one multiplier bit per cycle, XLEN cycles.
  - mulh: operands are converted to magnitudes and the product is negated at the end if the signs differ.
  - Then → DONE. OUT_VALID is high XLEN+1 cycles after accept.
- DIV:
  - Restoring divider, one quotient bit per cycle, XLEN cycles.
  - Then → DONE. Latency is XLEN+1.
  - Y==0 takes the fast path: divu returns all ones; remu returns X.
- DONE:
  - OUT_VALID=1. RESULT is held stable while OUT_READY=0.
  - On an edge with OUT_READY=1: → IDLE, and OUT_VALID drops the next cycle.
  - There is no same-cycle re-accept; back-to-back single-cycle throughput is one op per 2 cycles.
- Iteration counter: SHW+1 bits, loaded with XLEN on entry to MUL/DIV, decremented each cycle. The op finishes on the edge where the counter equals 1.
- ABORT:
  - Sampled each edge. In MUL, DIV or DONE it forces IDLE and OUT_VALID=0. RESULT retains its old value and is don't-care.
  - ABORT together with IN_VALID in IDLE: the abort wins and nothing is accepted.
- RESET_N low mid-operation: immediate asynchronous return to the reset state. No partial result is ever presented.
- Operands are latched at accept. X, Y and OP may change freely afterward; only IS_EQUAL tracks them live.

Test Plan:
- Reset, then IN_VALID with OP=0, X=5, Y=7 → OUT_VALID one cycle after accept, RESULT=12. IS_EQUAL=0, and IS_EQUAL=1 when X=Y=9.
- OP=9 with X=-3, Y=4 at XLEN=64 → after 65 cycles RESULT=all ones (high half of -12). OP=8 with the same operands gives RESULT=-12.
- OP=10 with X=100, Y=7 → quotient 14 at latency 65; OP=11 → 2. OP=10 with Y=0 → 0xFFFF_FFFF_FFFF_FFFF at latency 1; OP=11 with Y=0 → X.
- OP=5 with X=1, Y=0x41 → RESULT=2 (shift masked to 1). OP=7 with X=0x8000_0000_0000_0000, Y=63 → all ones.
- Start OP=8, pulse ABORT at cycle 10 → OUT_VALID never asserts and IN_READY=1 next cycle. Repeat with RESET_N low at cycle 20 → outputs zero immediately.
- Result back-pressure: hold OUT_READY=0 for 5 cycles in DONE → RESULT and OUT_VALID stable and IN_READY=0. Release → the next op is accepted 1 cycle later. Also rerun the full suite with XLEN=8.
